// File: rtl/vec_instr_encoder_pkg.sv
// Shared field layout and opcode map for the 32-bit vector instruction word.
// Both the encoder (producer) and decode (consumer) import this package.
package vec_instr_encoder_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned IMM_W   = 19;
  localparam int unsigned BYTE_W  = 8;

  // Field positions inside the instruction word.
  localparam int unsigned OPC_HI       = 31;
  localparam int unsigned OPC_LO       = 27;
  localparam int unsigned VK_HI        = 26;
  localparam int unsigned VK_LO        = 23;
  localparam int unsigned RK_HI        = 22;
  localparam int unsigned RK_LO        = 19;
  localparam int unsigned IMM_HI       = 18;
  localparam int unsigned IMM_LO       = 0;
  localparam int unsigned IMM_MODE_BIT = 14;
  localparam int unsigned BYTE_HI      = 7;
  localparam int unsigned BYTE_LO      = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_NOOP  = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_XOR   = 5'd3,
    OP_AND   = 5'd4,
    OP_ORR   = 5'd5,
    OP_LDV_I = 5'd6,
    OP_STR_I = 5'd7,
    OP_LDV_R = 5'd8,
    OP_STR_R = 5'd9,
    OP_MOVS  = 5'd10,
    OP_MOVV  = 5'd11,
    OP_SLV   = 5'd12,
    OP_SRV   = 5'd13,
    OP_ROL   = 5'd14,
    OP_ROR   = 5'd15
  } opcode_e;

  // Field-level request as presented by the sequencer.
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  vk;
    logic [REG_W-1:0]  rk;
    logic [IMM_W-1:0]  imm;
    logic              imm_mode;
    logic [BYTE_W-1:0] byte_imm;
  } vec_req_t;

  function automatic logic is_shift_op(input logic [OPC_W-1:0] opc);
    return (opc == OP_SLV) || (opc == OP_SRV) || (opc == OP_ROL) || (opc == OP_ROR);
  endfunction

  function automatic logic is_known_opcode(input logic [OPC_W-1:0] opc);
    logic known;
    case (opc)
      OP_NOOP, OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_ORR,
      OP_LDV_I, OP_STR_I, OP_LDV_R, OP_STR_R, OP_MOVS, OP_MOVV,
      OP_SLV, OP_SRV, OP_ROL, OP_ROR: known = 1'b1;
      default:                         known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/vec_instr_fifo.sv
// Synchronous FIFO holding encoded instruction words for decode.
// Ports: clk, rst (sync, active-high), flush (sync discard), push/wdata,
//        pop/rdata (head, zero when empty), full, empty, count.
module vec_instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next-state: flush wins over push and pop; pointers wrap on power-of-two depth.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: reads are masked by empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vec_instr_encoder.sv
// Packs field-level requests into 32-bit vector instruction words and buffers
// them towards decode.
// Ports: clk, rst (sync, active-high); req_* request handshake and fields;
//        flush; out_valid/out_ready/out_instr to decode; count; err.
// Option: define VEC_ENC_CHECK_EN to drop unknown opcodes and shift ops with a
//         stray byte immediate (handshake completes, err pulses one cycle).
module vec_instr_encoder
  import vec_instr_encoder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [OPC_W-1:0]           req_opcode,
  input  logic [REG_W-1:0]           req_vk,
  input  logic [REG_W-1:0]           req_rk,
  input  logic [IMM_W-1:0]           req_imm,
  input  logic                       req_imm_mode,
  input  logic [BYTE_W-1:0]          req_byte,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  vec_req_t           req;
  logic [INSTR_W-1:0] packed_instr;
  logic               accept;
  logic               reject;
  logic               full;
  logic               empty;

  assign req = {req_opcode, req_vk, req_rk, req_imm, req_imm_mode, req_byte};

  // Field packer: every bit not owned by the opcode's format stays zero.
  always_comb begin
    packed_instr                = '0;
    packed_instr[OPC_HI:OPC_LO] = req.opcode;
    case (req.opcode)
      OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_ORR: begin
        packed_instr[VK_HI:VK_LO] = req.vk;
        packed_instr[RK_HI:RK_LO] = req.rk;
      end
      OP_LDV_I, OP_STR_I: begin
        packed_instr[VK_HI:VK_LO]   = req.vk;
        packed_instr[IMM_HI:IMM_LO] = req.imm;
      end
      OP_LDV_R, OP_STR_R: begin
        packed_instr[VK_HI:VK_LO]   = req.vk;
        packed_instr[RK_HI:RK_LO]   = req.rk;
        packed_instr[IMM_HI:IMM_LO] = req.imm;
      end
      OP_MOVS: begin
        packed_instr[RK_HI:RK_LO]   = req.rk;
        packed_instr[IMM_HI:IMM_LO] = req.imm;
      end
      OP_MOVV: begin
        packed_instr[VK_HI:VK_LO]     = req.vk;
        packed_instr[BYTE_HI:BYTE_LO] = req.byte_imm;
      end
      OP_SLV, OP_SRV, OP_ROL, OP_ROR: begin
        packed_instr[VK_HI:VK_LO]   = req.vk;
        packed_instr[IMM_MODE_BIT]  = req.imm_mode;
        if (req.imm_mode) begin
          packed_instr[BYTE_HI:BYTE_LO] = req.byte_imm;
        end
      end
      default: ;  // NOOP and unknown opcodes carry only the opcode
    endcase
  end

  assign req_ready = !full && !rst;
  assign accept    = req_valid && req_ready;
  assign out_valid = !empty;

`ifdef VEC_ENC_CHECK_EN
  logic err_q, err_d;

  assign reject = !is_known_opcode(req.opcode) ||
                  (is_shift_op(req.opcode) && !req.imm_mode && (req.byte_imm != '0));

  // A flushed request is dropped silently, so it never raises err.
  always_comb begin
    err_d = accept && reject && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  vec_instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (accept && !reject),
    .wdata (packed_instr),
    .pop   (out_valid && out_ready),
    .rdata (out_instr),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_vec_instr_encoder.sv
// Scoreboard bench for vec_instr_encoder: the driver pushes hand-computed
// expected words as requests are accepted; a monitor pops and compares on
// every output handshake and checks out_instr stability during stalls.
module tb_vec_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned NVEC  = 18;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_opcode;
  logic [3:0]       req_vk;
  logic [3:0]       req_rk;
  logic [18:0]      req_imm;
  logic             req_imm_mode;
  logic [7:0]       req_byte;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [CNT_W-1:0] count;
  logic             err;

  vec_instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_vk       (req_vk),
    .req_rk       (req_rk),
    .req_imm      (req_imm),
    .req_imm_mode (req_imm_mode),
    .req_byte     (req_byte),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .count        (count),
    .err          (err)
  );

  typedef struct {
    logic [4:0]  opc;
    logic [3:0]  vk;
    logic [3:0]  rk;
    logic [18:0] imm;
    logic        mode;
    logic [7:0]  b;
    logic        rej;   // dropped when the checker option is built in
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [NVEC];
  logic [31:0] exp_q [$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          ready_mode = 1;  // 0: always ready, 1: stalled, 2: random
  logic        prev_hold = 1'b0;
  logic [31:0] prev_instr = '0;
  logic        exp_err_next = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-encoded vectors; unused fields carry junk to prove they are masked.
  task automatic init_tbl();
    tbl[0]  = '{5'd0,  4'hF, 4'hF, 19'h7FFFF, 1'b1, 8'hFF, 1'b0, 32'h0000_0000};
    tbl[1]  = '{5'd1,  4'h3, 4'h5, 19'h12345, 1'b1, 8'h55, 1'b0, {5'd1, 4'd3, 4'd5, 19'd0}};
    tbl[2]  = '{5'd2,  4'hA, 4'h1, 19'h00001, 1'b0, 8'h01, 1'b0, {5'd2, 4'hA, 4'h1, 19'd0}};
    tbl[3]  = '{5'd3,  4'h0, 4'hF, 19'h7FFFF, 1'b0, 8'hFF, 1'b0, {5'd3, 4'h0, 4'hF, 19'd0}};
    tbl[4]  = '{5'd4,  4'h7, 4'h8, 19'h00000, 1'b1, 8'h00, 1'b0, {5'd4, 4'h7, 4'h8, 19'd0}};
    tbl[5]  = '{5'd5,  4'hF, 4'h0, 19'h55555, 1'b0, 8'h3C, 1'b0, {5'd5, 4'hF, 4'h0, 19'd0}};
    tbl[6]  = '{5'd6,  4'h2, 4'h9, 19'h7FFFF, 1'b1, 8'hEE, 1'b0, {5'd6, 4'h2, 4'h0, 19'h7FFFF}};
    tbl[7]  = '{5'd7,  4'h4, 4'h3, 19'h01234, 1'b0, 8'h11, 1'b0, {5'd7, 4'h4, 4'h0, 19'h01234}};
    tbl[8]  = '{5'd8,  4'h2, 4'h7, 19'h40F0F, 1'b1, 8'h99, 1'b0, {5'd8, 4'h2, 4'h7, 19'h40F0F}};
    tbl[9]  = '{5'd9,  4'h9, 4'hC, 19'h2AAAA, 1'b0, 8'h77, 1'b0, {5'd9, 4'h9, 4'hC, 19'h2AAAA}};
    tbl[10] = '{5'd10, 4'h5, 4'h6, 19'h30001, 1'b1, 8'hFF, 1'b0, {5'd10, 4'h0, 4'h6, 19'h30001}};
    tbl[11] = '{5'd11, 4'h1, 4'h7, 19'h7FFFF, 1'b1, 8'hA5, 1'b0, {5'd11, 4'h1, 4'h0, 11'd0, 8'hA5}};
    tbl[12] = '{5'd14, 4'h6, 4'hF, 19'h7FFFF, 1'b1, 8'h03, 1'b0, {5'd14, 4'h6, 4'h0, 4'h0, 1'b1, 6'd0, 8'h03}};
    tbl[13] = '{5'd14, 4'h6, 4'hF, 19'h7FFFF, 1'b0, 8'h03, 1'b1, {5'd14, 4'h6, 23'd0}};
    tbl[14] = '{5'd12, 4'hB, 4'h2, 19'h00000, 1'b1, 8'h80, 1'b0, {5'd12, 4'hB, 4'h0, 4'h0, 1'b1, 6'd0, 8'h80}};
    tbl[15] = '{5'd13, 4'h3, 4'h4, 19'h1FFFF, 1'b0, 8'h00, 1'b0, {5'd13, 4'h3, 23'd0}};
    tbl[16] = '{5'd15, 4'hD, 4'h1, 19'h00F00, 1'b1, 8'h1F, 1'b0, {5'd15, 4'hD, 4'h0, 4'h0, 1'b1, 6'd0, 8'h1F}};
    tbl[17] = '{5'd20, 4'hF, 4'hF, 19'h7FFFF, 1'b1, 8'hFF, 1'b1, {5'd20, 27'd0}};
  endtask

  task automatic load_req(input int idx);
    req_opcode   = tbl[idx].opc;
    req_vk       = tbl[idx].vk;
    req_rk       = tbl[idx].rk;
    req_imm      = tbl[idx].imm;
    req_imm_mode = tbl[idx].mode;
    req_byte     = tbl[idx].b;
  endtask

  task automatic push_exp(input int idx);
`ifdef VEC_ENC_CHECK_EN
    if (!tbl[idx].rej) exp_q.push_back(tbl[idx].exp);
`else
    exp_q.push_back(tbl[idx].exp);
`endif
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send(input int idx);
    bit done = 1'b0;
    load_req(idx);
    req_valid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
        push_exp(idx);
      end
      tick();
    end
    req_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drained(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      if (count == '0 && !out_valid && exp_q.size() == 0) done = 1'b1;
      tick();
    end
    chk(name, 32'(done), 32'd1);
  endtask

  // out_ready is updated just after the driver's posedge+1 slot.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pop, stall stability and err pulse.
  always @(negedge clk) begin
    logic [31:0] e;
    logic        rj;
    if (prev_hold) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_stable", out_instr, prev_instr);
    end
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", out_instr, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard_word", out_instr, e);
      end
    end
    chk("err_pulse", 32'(err), 32'(exp_err_next));
`ifdef VEC_ENC_CHECK_EN
    rj = (req_opcode > 5'd15) ||
         (req_opcode >= 5'd12 && !req_imm_mode && req_byte != 8'h00);
    exp_err_next = !rst && !flush && req_valid && req_ready && rj;
`else
    rj = 1'b0;
    exp_err_next = rj;
`endif
    prev_hold  = out_valid && !out_ready && !rst && !flush;
    prev_instr = out_instr;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
    req_opcode = '0; req_vk = '0; req_rk = '0; req_imm = '0;
    req_imm_mode = 1'b0; req_byte = '0;
    init_tbl();

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    tick();

    // One-cycle latency: ADD vk=3 rk=5.
    ready_mode = 0;
    tick();
    send(1);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_add_word", out_instr, {5'd1, 4'd3, 4'd5, 19'd0});
    chk("lat_count", 32'(count), 32'd1);
    tick();
    foreach (tbl[i]) send(i);
    wait_drained("drain_directed");

    // Fill to DEPTH with out_ready low; the fifth request must wait for a pop.
    ready_mode = 1;
    tick();
    for (int k = 2; k < 6; k++) send(k);
    load_req(6);
    req_valid = 1'b1;
    @(negedge clk);
    chk("full_count", 32'(count), 32'd4);
    chk("full_req_ready", 32'(req_ready), 32'd0);
    chk("full_head", out_instr, {5'd2, 4'hA, 4'h1, 19'd0});
    tick();
    @(negedge clk);
    chk("full_hold_ready", 32'(req_ready), 32'd0);
    tick();
    ready_mode = 0;
    @(negedge clk);
    chk("full_until_pop", 32'(req_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("ready_after_pop", 32'(req_ready), 32'd1);
    chk("count_after_pop", 32'(count), 32'd3);
    if (req_ready) push_exp(6);
    tick();
    req_valid = 1'b0;
    wait_drained("drain_full");

    // Random stalls over 200 requests.
    ready_mode = 2;
    for (int i = 0; i < 200; i++) send(i % NVEC);
    ready_mode = 0;
    wait_drained("drain_random");

    // Flush with three buffered words and a concurrent request.
    ready_mode = 1;
    tick();
    send(8); send(9); send(10);
    @(negedge clk);
    chk("pre_flush_count", 32'(count), 32'd3);
    tick();
    load_req(1);
    req_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    exp_q.delete();
    tick();
    req_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_instr", out_instr, 32'd0);
    tick();

    // Reset mid-stream.
    send(11); send(12);
    load_req(14);
    req_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_out_instr", out_instr, 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready_back", 32'(req_ready), 32'd1);
    tick();
    ready_mode = 0;
    send(8);
    wait_drained("drain_after_rst");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
